dmem_arbiter: RTL and testbench

//  Two-master arbiter for the single-port data memory (dmem: combinational read, write on posedge clk).

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/dmem_arb_pick.sv | 32 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and master indices.
// No logic here.
package dmem_arb_pkg;

    localparam logic ARB    = 1'b0;
    localparam logic LOCKED = 1'b1;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection for the two dmem masters; purely combinational, zero latency.
// Backpressure: a requester that is not picked simply sees gnt=0 and holds its request.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       state,
    input  logic       lock_owner,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = M_CPU;
        if (state == LOCKED) begin
            // The locked master is the only candidate; the other one waits.
            winner          = lock_owner;
            gnt[lock_owner] = req[lock_owner];
        end else begin
            if (req == 2'b11)
                winner = rr_ptr;
            else if (req[M_DBG])
                winner = M_DBG;
            else
                winner = M_CPU;
            gnt[winner] = |req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master single-port dmem arbiter with bounded locked bursts; DMEM_ARB_RR_EN selects round-robin ties, else master 0 wins.
// Latency: grant and write in the request cycle, read data registered one cycle later; losers see gnt=0 and must hold.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_BITS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic             m0_lock,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_rvalid,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic             m1_lock,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_rvalid,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             owner
);

    logic                state;
    logic                lock_owner;
    logic [CNT_BITS-1:0] burst_cnt;
    logic                rr_ptr;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                winner;
    logic                any_gnt;
    logic                win_lock;
    logic                burst_full;

    // A locked master that has used up its beats is masked here so the picker
    // only ever sees "no request" and the FSM falls back to ARB.
    assign burst_full = (state == LOCKED) && (burst_cnt >= CNT_BITS'(MAX_BURST));
    assign req        = (reset || burst_full) ? 2'b00 : {m1_req, m0_req};

    dmem_arb_pick u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .state      (state),
        .lock_owner (lock_owner),
        .gnt        (gnt),
        .winner     (winner)
    );

    assign any_gnt  = |gnt;
    assign win_lock = winner ? m1_lock : m0_lock;
    assign m0_gnt   = gnt[M_CPU];
    assign m1_gnt   = gnt[M_DBG];
    assign owner    = gnt[M_DBG];

    assign mem_we    = gnt[M_DBG] ? m1_we    : (gnt[M_CPU] & m0_we);
    assign mem_addr  = gnt[M_DBG] ? m1_addr  : m0_addr;
    assign mem_wdata = gnt[M_DBG] ? m1_wdata : m0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            lock_owner <= M_CPU;
            burst_cnt  <= '0;
        end else if (state == ARB) begin
            if (any_gnt && win_lock) begin
                state      <= LOCKED;
                lock_owner <= winner;
                burst_cnt  <= CNT_BITS'(1);
            end
        end else begin
            if (any_gnt && win_lock) begin
                burst_cnt <= burst_cnt + CNT_BITS'(1);
            end else begin
                state     <= ARB;
                burst_cnt <= '0;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Every exit from LOCKED (early unlock, idle owner, forced release) hands the tie to the other master.
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= M_CPU;
        else if (state == LOCKED)
            rr_ptr <= ~lock_owner;
        else if (any_gnt)
            rr_ptr <= ~winner;
    end
`else
    assign rr_ptr = M_CPU;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= gnt[M_CPU] & ~m0_we;
            m1_rvalid <= gnt[M_DBG] & ~m1_we;
            if (gnt[M_CPU] && !m0_we)
                m0_rdata <= mem_rdata;
            if (gnt[M_DBG] && !m1_we)
                m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word dmem model behind it.
// Build with or without DMEM_ARB_RR_EN; tie expectations follow the macro.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [64];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr[7:2]] <= mem_wdata;
        else if (pl_we)
            ram[pl_idx] <= pl_dat;
    end

    dmem_arbiter #(.WIDTH(32), .MAX_BURST(4), .CNT_BITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_all();
        tick();
        reset = 1'b0;
    endtask

    task automatic pl_write(input logic [5:0] idx, input logic [31:0] dat);
        pl_we = 1'b1; pl_idx = idx; pl_dat = dat;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_w;
        reset = 1'b1;
        idle_all();
        pl_write(6'd2, 32'h1234);
        pl_write(6'd10, 32'h0);
        pl_write(6'd63, 32'h0);

        // Reset state: requests (including writes) are ignored while reset is high.
        m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
        settle();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        idle_all();
        tick();
        reset = 1'b0;

        // 1. Single read from m0.
        m0_req = 1; m0_addr = 32'd8;
        settle();
        chk("t1_m0_gnt", m0_gnt, 1);
        chk("t1_m1_gnt", m1_gnt, 0);
        chk("t1_mem_addr", mem_addr, 32'd8);
        chk("t1_mem_we", mem_we, 0);
        tick();
        idle_all();
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        tick();
        chk("t1_rvalid_pulse", m0_rvalid, 0);

        // 2. Contention: both write every cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_req = 1; m0_we = 1; m0_addr = 32'd16; m0_wdata = 32'd100 + i;
            m1_req = 1; m1_we = 1; m1_addr = 32'd20; m1_wdata = 32'd200 + i;
`ifdef DMEM_ARB_RR_EN
            exp_w = (i % 2 == 1);
`else
            exp_w = 1'b0;
`endif
            settle();
            chk("t2_m1_gnt", m1_gnt, exp_w);
            chk("t2_m0_gnt", m0_gnt, !exp_w);
            chk("t2_owner", owner, exp_w);
            chk("t2_mem_wdata", mem_wdata, exp_w ? 32'd200 + i : 32'd100 + i);
            tick();
        end
        idle_all();

        // 3. m1 locked burst with forced release after 4 beats.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            m1_req = 1; m1_lock = 1; m1_addr = 32'(4 * c);
            m0_req = (c > 0); m0_addr = 32'd8;
            settle();
            chk("t3_m1_gnt", m1_gnt, c < 4);
            chk("t3_m0_gnt", m0_gnt, c == 5);
            if (c > 0)
                chk("t3_m1_rvalid", m1_rvalid, c <= 4);
            tick();
        end
        idle_all();

        // 4. Early unlock by m0 on its second beat.
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'd8; m1_req = 1; m1_addr = 32'd8;
        settle();
        chk("t4_b1_m0_gnt", m0_gnt, 1);
        tick();
        m0_lock = 0;
        settle();
        chk("t4_b2_m0_gnt", m0_gnt, 1);
        chk("t4_b2_m1_gnt", m1_gnt, 0);
        tick();
        settle();
`ifdef DMEM_ARB_RR_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        chk("t4_next_m1_gnt", m1_gnt, exp_w);
        chk("t4_next_m0_gnt", m0_gnt, !exp_w);
        tick();
        idle_all();

        // 5. Reset on m1's second locked read.
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 32'd8;
        settle();
        chk("t5_b1_m1_gnt", m1_gnt, 1);
        tick();
        reset = 1'b1;
        m0_req = 1; m0_we = 1; m0_addr = 32'd40; m0_wdata = 32'hdead;
        settle();
        chk("t5_rst_m1_gnt", m1_gnt, 0);
        chk("t5_rst_m0_gnt", m0_gnt, 0);
        chk("t5_rst_mem_we", mem_we, 0);
        tick();
        reset = 1'b0;
        m0_we = 0; m0_addr = 32'd8; m1_lock = 0;
        settle();
        chk("t5_m1_rvalid", m1_rvalid, 0);
        chk("t5_ram10", ram[10], 32'h0);
        chk("t5_tie_m0_gnt", m0_gnt, 1);
        chk("t5_tie_m1_gnt", m1_gnt, 0);
        tick();
        idle_all();
        chk("t5_m0_rdata", m0_rdata, 32'h1234);

        // 6. Read-after-write by m1.
        m1_req = 1; m1_we = 1; m1_addr = 32'd252; m1_wdata = 32'd210;
        settle();
        chk("t6_w_gnt", m1_gnt, 1);
        chk("t6_w_mem_we", mem_we, 1);
        tick();
        m1_we = 0;
        settle();
        chk("t6_r_gnt", m1_gnt, 1);
        tick();
        idle_all();
        chk("t6_rvalid", m1_rvalid, 1);
        chk("t6_rdata", m1_rdata, 32'd210);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
